// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction-fetch unit:
// fetch FSM states, NOP encoding and the AXI constants used on the read port.
package ifu_fetch_pkg;

    localparam int CPU_WIDTH  = 64;
    localparam int INST_WIDTH = 32;

    localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
    localparam logic [2:0] AXI_SIZE_8B   = 3'b011;

    typedef enum logic [2:0] {
        IFU_IDLE,
        IFU_AR,
        IFU_R,
        IFU_HOLD,
        IFU_DRAIN
    } ifu_state_e;

endpackage

// File: rtl/ifu_fetch_word_sel.sv
// Picks the 32-bit instruction out of a 64-bit read beat and flags bus errors.
// Ports: sel_hi_i (pc bit 2), data_i (beat), resp_i (AXI resp) -> inst_o, err_o.
module ifu_fetch_word_sel
    import ifu_fetch_pkg::*;
(
    input  logic                  sel_hi_i,
    input  logic [CPU_WIDTH-1:0]  data_i,
    input  logic [1:0]            resp_i,
    output logic [INST_WIDTH-1:0] inst_o,
    output logic                  err_o
);

    logic [INST_WIDTH-1:0] word;

    assign word   = sel_hi_i ? data_i[63:32] : data_i[31:0];
    assign err_o  = (resp_i != AXI_RESP_OKAY);
    // A faulted fetch hands a harmless NOP downstream; err_o marks it.
    assign inst_o = err_o ? NOP_INST : word;

endmodule

// File: rtl/ifu_fetch.sv
// Fetch side of the bru PC handshake: one single-beat AXI read per PC,
// result held for IF/ID until accepted or killed.
// Ports: i_clk/i_rst_n; i_pc, i_kill from bru; o_br_fetch_valid /
// i_br_fetch_ready with o_inst, o_inst_pc, o_fetch_err; AXI AR and R
// channels; o_busy while any fetch is in flight or held.
module ifu_fetch
    import ifu_fetch_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [CPU_WIDTH-1:0]  i_pc,
    input  logic                  i_kill,
    output logic                  o_br_fetch_valid,
    input  logic                  i_br_fetch_ready,
    output logic [INST_WIDTH-1:0] o_inst,
    output logic [CPU_WIDTH-1:0]  o_inst_pc,
    output logic                  o_fetch_err,
    output logic                  o_ar_valid,
    input  logic                  i_ar_ready,
    output logic [CPU_WIDTH-1:0]  o_ar_addr,
    output logic [2:0]            o_ar_size,
    input  logic                  i_r_valid,
    output logic                  o_r_ready,
    input  logic [CPU_WIDTH-1:0]  i_r_data,
    input  logic [1:0]            i_r_resp,
    output logic                  o_busy
);

    ifu_state_e            state_q;
    logic [CPU_WIDTH-1:0]  pc_q;
    logic [CPU_WIDTH-1:0]  inst_pc_q;
    logic [INST_WIDTH-1:0] inst_q;
    logic                  err_q;
    logic                  valid_q;
    logic                  ar_valid_q;
    logic                  r_ready_q;
    logic                  kill_pend_q;

    logic [INST_WIDTH-1:0] inst_d;
    logic                  err_d;

    ifu_fetch_word_sel u_word_sel (
        .sel_hi_i (pc_q[2]),
        .data_i   (i_r_data),
        .resp_i   (i_r_resp),
        .inst_o   (inst_d),
        .err_o    (err_d)
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= IFU_IDLE;
            pc_q        <= '0;
            inst_pc_q   <= '0;
            inst_q      <= NOP_INST;
            err_q       <= 1'b0;
            valid_q     <= 1'b0;
            ar_valid_q  <= 1'b0;
            r_ready_q   <= 1'b0;
            kill_pend_q <= 1'b0;
        end else begin
            unique case (state_q)
                IFU_IDLE: begin
                    pc_q        <= i_pc;
                    kill_pend_q <= 1'b0;
                    if (!i_kill) begin
                        if (i_pc[1:0] != 2'b00) begin
                            // Misaligned: report without a bus request.
                            state_q   <= IFU_HOLD;
                            valid_q   <= 1'b1;
                            err_q     <= 1'b1;
                            inst_q    <= NOP_INST;
                            inst_pc_q <= i_pc;
                        end else begin
                            state_q    <= IFU_AR;
                            ar_valid_q <= 1'b1;
                        end
                    end
                end
                IFU_AR: begin
                    // AR may not be withdrawn; a kill is remembered
                    // and the response is drained instead.
                    if (i_ar_ready) begin
                        ar_valid_q <= 1'b0;
                        r_ready_q  <= 1'b1;
                        if (i_kill || kill_pend_q)
                            state_q <= IFU_DRAIN;
                        else
                            state_q <= IFU_R;
                    end else if (i_kill) begin
                        kill_pend_q <= 1'b1;
                    end
                end
                IFU_R: begin
                    if (i_r_valid) begin
                        r_ready_q <= 1'b0;
                        if (i_kill || kill_pend_q) begin
                            state_q <= IFU_IDLE;
                        end else begin
                            state_q   <= IFU_HOLD;
                            valid_q   <= 1'b1;
                            inst_q    <= inst_d;
                            err_q     <= err_d;
                            inst_pc_q <= pc_q;
                        end
                    end else if (i_kill) begin
                        kill_pend_q <= 1'b1;
                    end
                end
                IFU_DRAIN: begin
                    if (i_r_valid) begin
                        r_ready_q <= 1'b0;
                        state_q   <= IFU_IDLE;
                    end
                end
                IFU_HOLD: begin
                    // Kill and accept both release the slot.
                    if (i_kill || i_br_fetch_ready) begin
                        valid_q <= 1'b0;
                        state_q <= IFU_IDLE;
                    end
                end
                default: state_q <= IFU_IDLE;
            endcase
        end
    end

    assign o_br_fetch_valid = valid_q;
    assign o_inst           = inst_q;
    assign o_inst_pc        = inst_pc_q;
    assign o_fetch_err      = err_q;
    assign o_ar_valid       = ar_valid_q;
    assign o_ar_addr        = {pc_q[CPU_WIDTH-1:3], 3'b000};
    assign o_ar_size        = AXI_SIZE_8B;
    assign o_r_ready        = r_ready_q;
    assign o_busy           = (state_q != IFU_IDLE);

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch with a zero-wait AXI read slave model.
// Ports driven: PC/kill/ready from bru side, AR/R responses from slave.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] pc;
    logic        kill;
    logic        ready;
    logic        ar_ready;
    logic        r_valid;
    logic [63:0] r_data;
    logic [1:0]  r_resp;

    logic        o_valid;
    logic [31:0] o_inst;
    logic [63:0] o_inst_pc;
    logic        o_err;
    logic        o_ar_valid;
    logic [63:0] o_ar_addr;
    logic [2:0]  o_ar_size;
    logic        o_r_ready;
    logic        o_busy;

    int n_cmp = 0;
    int n_err = 0;
    int n_hs  = 0;

    always #5 clk = ~clk;

    ifu_fetch dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_pc             (pc),
        .i_kill           (kill),
        .o_br_fetch_valid (o_valid),
        .i_br_fetch_ready (ready),
        .o_inst           (o_inst),
        .o_inst_pc        (o_inst_pc),
        .o_fetch_err      (o_err),
        .o_ar_valid       (o_ar_valid),
        .i_ar_ready       (ar_ready),
        .o_ar_addr        (o_ar_addr),
        .o_ar_size        (o_ar_size),
        .i_r_valid        (r_valid),
        .o_r_ready        (o_r_ready),
        .i_r_data         (r_data),
        .i_r_resp         (r_resp),
        .o_busy           (o_busy)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // One clock; slave reacts to handshakes seen before the edge,
    // then outputs are sampled 1 time unit after it.
    task automatic step();
        logic ar_hs;
        logic r_hs;
        logic f_hs;
        ar_hs = o_ar_valid & ar_ready;
        r_hs  = o_r_ready & r_valid;
        f_hs  = o_valid & ready & ~kill;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            r_valid = 1'b0;
        end else begin
            if (r_hs)  r_valid = 1'b0;
            if (ar_hs) r_valid = 1'b1;
            if (f_hs)  n_hs++;
        end
    endtask

    task automatic wait_valid(input string tag,
                              input int maxc,
                              output int n);
        n = 0;
        while (!o_valid && n < maxc) begin
            step();
            n++;
        end
        chk(tag, {63'd0, o_valid}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int n;
        int hs0;
        rst_n    = 1'b0;
        pc       = 64'h0;
        kill     = 1'b0;
        ready    = 1'b1;
        ar_ready = 1'b1;
        r_valid  = 1'b0;
        r_data   = 64'h0000_0093_0000_0013;
        r_resp   = 2'b00;
        step();
        step();
        chk("rst_valid", {63'd0, o_valid}, 64'd0);
        chk("rst_arv", {63'd0, o_ar_valid}, 64'd0);
        chk("rst_rrdy", {63'd0, o_r_ready}, 64'd0);
        chk("rst_busy", {63'd0, o_busy}, 64'd0);
        chk("rst_err", {63'd0, o_err}, 64'd0);
        chk("rst_inst", {32'd0, o_inst}, 64'h13);
        chk("rst_ipc", o_inst_pc, 64'h0);
        chk("rst_addr", o_ar_addr, 64'h0);
        chk("ar_size", {61'd0, o_ar_size}, 64'd3);

        // 1: aligned low word, zero-wait slave
        rst_n = 1'b1;
        pc    = 64'h8000_0000;
        step();
        chk("t1_arv", {63'd0, o_ar_valid}, 64'd1);
        chk("t1_addr", o_ar_addr, 64'h8000_0000);
        chk("t1_busy", {63'd0, o_busy}, 64'd1);
        step();
        chk("t1_rrdy", {63'd0, o_r_ready}, 64'd1);
        chk("t1_novld", {63'd0, o_valid}, 64'd0);
        step();
        chk("t1_valid", {63'd0, o_valid}, 64'd1);
        chk("t1_inst", {32'd0, o_inst}, 64'h13);
        chk("t1_ipc", o_inst_pc, 64'h8000_0000);
        chk("t1_err", {63'd0, o_err}, 64'd0);
        step();
        chk("t1_drop", {63'd0, o_valid}, 64'd0);
        chk("t1_idle", {63'd0, o_busy}, 64'd0);
        chk("t1_hs", n_hs, 64'd1);

        // 2: high word of the same beat
        pc = 64'h8000_0004;
        step();
        chk("t2_arv", {63'd0, o_ar_valid}, 64'd1);
        chk("t2_addr", o_ar_addr, 64'h8000_0000);
        wait_valid("t2_valid", 10, n);
        chk("t2_lat", n, 64'd2);
        chk("t2_inst", {32'd0, o_inst}, 64'h93);
        chk("t2_ipc", o_inst_pc, 64'h8000_0004);
        step();
        chk("t2_hs", n_hs, 64'd2);

        // 3: AR stalled, kill mid-stall, response drained
        pc       = 64'h8000_0008;
        ar_ready = 1'b0;
        step();
        chk("t3_arv0", {63'd0, o_ar_valid}, 64'd1);
        for (int i = 0; i < 4; i++) begin
            kill = (i == 1);
            if (i == 1) pc = 64'h8000_0100;
            step();
            chk($sformatf("t3_arv%0d", i), {63'd0, o_ar_valid}, 64'd1);
            chk($sformatf("t3_addr%0d", i), o_ar_addr, 64'h8000_0008);
        end
        kill     = 1'b0;
        ar_ready = 1'b1;
        step();
        chk("t3_drain_rr", {63'd0, o_r_ready}, 64'd1);
        chk("t3_drain_nv", {63'd0, o_valid}, 64'd0);
        step();
        chk("t3_idle_nv", {63'd0, o_valid}, 64'd0);
        chk("t3_idle", {63'd0, o_busy}, 64'd0);
        r_data = 64'h0000_0093_0040_0113;
        step();
        chk("t3_redir", o_ar_addr, 64'h8000_0100);
        wait_valid("t3_valid", 10, n);
        chk("t3_inst", {32'd0, o_inst}, 64'h0040_0113);
        chk("t3_ipc", o_inst_pc, 64'h8000_0100);
        step();
        chk("t3_hs", n_hs, 64'd3);

        // 4: slave error response
        pc     = 64'h8000_0104;
        r_resp = 2'b10;
        wait_valid("t4_valid", 10, n);
        chk("t4_lat", n, 64'd3);
        chk("t4_err", {63'd0, o_err}, 64'd1);
        chk("t4_inst", {32'd0, o_inst}, 64'h13);
        chk("t4_ipc", o_inst_pc, 64'h8000_0104);
        step();
        r_resp = 2'b00;

        // 5: misaligned PC, hold under backpressure, kill wins
        pc    = 64'h8000_0002;
        ready = 1'b0;
        step();
        chk("t5_noar", {63'd0, o_ar_valid}, 64'd0);
        chk("t5_valid", {63'd0, o_valid}, 64'd1);
        chk("t5_err", {63'd0, o_err}, 64'd1);
        chk("t5_ipc", o_inst_pc, 64'h8000_0002);
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("t5_hold%0d", i), {63'd0, o_valid}, 64'd1);
            chk($sformatf("t5_inst%0d", i), {32'd0, o_inst}, 64'h13);
            chk($sformatf("t5_noar%0d", i), {63'd0, o_ar_valid}, 64'd0);
        end
        hs0   = n_hs;
        kill  = 1'b1;
        ready = 1'b1;
        step();
        kill = 1'b0;
        chk("t5_kill_nv", {63'd0, o_valid}, 64'd0);
        chk("t5_kill_idle", {63'd0, o_busy}, 64'd0);
        chk("t5_no_hs", n_hs, hs0);

        // 6: reset while waiting for read data
        pc = 64'h8000_0200;
        step();
        step();
        chk("t6_in_r", {63'd0, o_r_ready}, 64'd1);
        rst_n = 1'b0;
        step();
        chk("t6_busy", {63'd0, o_busy}, 64'd0);
        chk("t6_rrdy", {63'd0, o_r_ready}, 64'd0);
        chk("t6_arv", {63'd0, o_ar_valid}, 64'd0);
        chk("t6_valid", {63'd0, o_valid}, 64'd0);
        chk("t6_err", {63'd0, o_err}, 64'd0);
        chk("t6_inst", {32'd0, o_inst}, 64'h13);
        chk("t6_ipc", o_inst_pc, 64'h0);
        rst_n = 1'b1;
        pc    = 64'h8000_0004;
        wait_valid("t6_after", 10, n);
        chk("t6_lat", n, 64'd3);
        chk("t6_inst2", {32'd0, o_inst}, 64'h93);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
